// File: rtl/msg_schedule_pkg.sv
// Shared constants, state encoding and rotate helper for the SHA-256 message schedule.
package msg_schedule_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned ROUND_CNT   = 64;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned T_W         = 6;

  // sigma0 / sigma1 rotate and shift amounts
  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Rotate right by n (0 < n < WORD_W)
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/msg_schedule_sigma.sv
// Combinational SHA-256 small sigma functions; shared with the round core.
module sha256_sigma
  import msg_schedule_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  assign s0 = rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  assign s1 = rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then emits W0..W63 from a 16-word sliding window.
module msg_schedule
  import msg_schedule_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = BLOCK_WORDS,
  parameter int unsigned ROUNDS          = ROUND_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] w_in,
  input  logic              w_load,
  input  logic              start,
  input  logic              next,
  output logic [WORD_W-1:0] w_out,
  output logic [T_W-1:0]    t_out,
  output logic              w_valid,
  output logic              full,
  output logic              busy,
  output logic              done,
  output logic              load_err
);

  state_t           state, state_nxt;
  word_t            win     [BLOCK_WORDS];
  word_t            win_nxt [BLOCK_WORDS];
  logic [CNT_W-1:0] ld_cnt, ld_cnt_nxt;
  logic [T_W-1:0]   t_nxt;
  logic             err_nxt;
  logic             blk_full;
  word_t            s0_w1, s1_w14, s1_unused, s0_unused, w_new;

  // sigma0 of w[1] and sigma1 of w[14] for the next expanded word
  sha256_sigma u_sig_w1  (.x(win[1]),  .s0(s0_w1),     .s1(s1_unused));
  sha256_sigma u_sig_w14 (.x(win[14]), .s0(s0_unused), .s1(s1_w14));

  assign w_new    = s1_w14 + win[9] + s0_w1 + win[0];
  assign blk_full = (ld_cnt == CNT_W'(WORDS_PER_BLOCK));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // Next-state, window, counters and error strobe
  always_comb begin
    state_nxt  = state;
    win_nxt    = win;
    ld_cnt_nxt = ld_cnt;
    t_nxt      = t_out;
    err_nxt    = 1'b0;
    unique case (state)
      ST_LOAD: begin
        if (w_load && !blk_full) begin
          for (int i = 0; i < 15; i++) win_nxt[i] = win[i+1];
          win_nxt[15] = w_in;
          ld_cnt_nxt  = ld_cnt + CNT_W'(1);
        end else begin
          err_nxt = w_load;
          if (start && blk_full) begin
            state_nxt = ST_RUN;
            t_nxt     = '0;
          end
        end
      end
      ST_RUN: begin
        err_nxt = w_load;
        if (next) begin
          if (t_out == T_W'(ROUNDS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            for (int i = 0; i < 15; i++) win_nxt[i] = win[i+1];
            win_nxt[15] = w_new;
            t_nxt       = t_out + T_W'(1);
          end
        end
      end
      ST_DONE: begin
        err_nxt    = w_load;
        ld_cnt_nxt = '0;
        state_nxt  = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Window, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      ld_cnt   <= '0;
      t_out    <= '0;
      w_out    <= '0;
      w_valid  <= 1'b0;
      full     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      win      <= win_nxt;
      ld_cnt   <= ld_cnt_nxt;
      t_out    <= t_nxt;
      w_out    <= (state_nxt == ST_RUN) ? win_nxt[0] : '0;
      w_valid  <= (state_nxt == ST_RUN);
      busy     <= (state_nxt == ST_RUN);
      done     <= (state_nxt == ST_DONE);
      full     <= (ld_cnt_nxt == CNT_W'(WORDS_PER_BLOCK));
      load_err <= err_nxt;
    end
  end

endmodule
